pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Next-PC unit for the single-cycle core; sits directly upstream of the 8-entry, 12-bit return-address stack.
- Drives the stack's push_sig/pop_sig/push_data and consumes its pop_data and overflow.
- Selects sequential, jump, branch, call and return targets.
- Shadows stack depth so an overflowing call or empty return halts the core with a fault instead of silently corrupting flow.

Parameters:
ADDR_W, 12, PC / target / stack data width
STACK_DEPTH, 8, return-stack entries mirrored by internal depth counter
RESET_PC, 12'h000, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold PC, suppress push/pop this cycle
is_jump  input  1  decoded unconditional jump
is_branch  input  1  decoded conditional branch
branch_taken  input  1  branch condition true
is_call  input  1  decoded call (jal)
is_ret  input  1  decoded return (jr ra)
is_halt  input  1  decoded halt
target  input  ADDR_W  jump/branch/call target
pop_data  input  ADDR_W  stack read data (valid cycle after pop edge)
overflow  input  1  stack overflow flag
pc  output  ADDR_W  current fetch address
push_sig  output  1  to stack: push this edge
pop_sig  output  1  to stack: pop this edge
push_data  output  ADDR_W  return address = pc+1
halted  output  1  core stopped
fault  output  1  sticky call-overflow / return-underflow / stack overflow error
depth  output  4  mirrored stack occupancy 0..STACK_DEPTH

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, state=RUN, depth=0, halted=0, fault=0.
- push_sig and pop_sig are 0 while in reset.
- States: RUN, RET_WAIT, HALT. pc, depth, halted, fault and state are registered.
- push_sig/pop_sig are combinational, gated by state==RUN && !stall; push_data=pc+1 always.
- RUN, stall=1: all registers hold; push_sig=pop_sig=0.
- RUN, decode priority is_halt > is_ret > is_call > is_jump > branch:
  - is_halt: next state HALT, halted=1.
  - is_ret: pop_sig=1; depth-1; next state RET_WAIT; pc holds.
  - is_call: push_sig=1; pc<=target; depth+1.
  - is_jump, or is_branch&&branch_taken: pc<=target.
  - otherwise: pc<=pc+1.
- RET_WAIT: pc<=pop_data; back to RUN. stall is ignored (one-cycle fixed). push/pop=0.
- Return latency: 2 cycles from ret fetch to target fetch. All other flow: 1 cycle.
- HALT: absorbing until reset; push/pop=0; pc holds.
- Arithmetic: pc+1 modulo 2^ADDR_W; 12'hFFF+1=12'h000, including push_data.
- overflow input high at any edge: fault<=1, state<=HALT.
- Reset asserted in RET_WAIT: abandons return; pop_data ignored.
- depth never wraps; pop and push are mutually exclusive by priority.

Optional Feature:
- Macro RAS_DEPTH_CHECK_EN.
- Defined:
  - is_call with depth==STACK_DEPTH: no push, fault<=1, HALT.
  - is_ret with depth==0: no pop, fault<=1, HALT.
  - Neither case changes pc.
- Undefined:
  - depth is still tracked but saturates at 0 and STACK_DEPTH.
  - Push/pop are always issued.
  - Empty return loads whatever pop_data holds.
  - Call overflow is caught only via the stack's overflow input on the following cycle.

Test Plan:
- Reset mid-run at pc=12'h005 -> pc=12'h000, depth=0, push/pop=0 immediately (async).
- Call at pc=12'h010, target=12'h100; then ret at 12'h103 -> push_data=12'h011 on call edge; pop_sig at ret edge; pc=12'h103 during RET_WAIT; pc=12'h011 next cycle; depth 1->0.
- Nine nested calls (define set) -> ninth call has push_sig=0, fault=1, halted=1, depth=8, pc frozen.
- Ret with depth=0 (define set) -> pop_sig=0, fault=1, halted=1; without the define -> pop_sig=1, pc<=pop_data.
- is_ret and is_call together, with stall toggling -> ret wins; stall=1 holds pc and issues no push/pop; branch taken to 12'h020 -> pc=12'h020; not taken at 12'hFFF -> pc=12'h000.
- is_halt -> halted=1, pc constant for 10 cycles, no push/pop until rst_n low.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC sequencer feeding an external return-address stack, with a mirrored stack depth.
// Define RAS_DEPTH_CHECK_EN to stop on call overflow or empty return before the stack is touched.
module pc_sequencer #(
    parameter int                 ADDR_W      = 12,
    parameter int                 STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              is_jump,
    input  logic              is_branch,
    input  logic              branch_taken,
    input  logic              is_call,
    input  logic              is_ret,
    input  logic              is_halt,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] pop_data,
    input  logic              overflow,
    output logic [ADDR_W-1:0] pc,
    output logic              push_sig,
    output logic              pop_sig,
    output logic [ADDR_W-1:0] push_data,
    output logic              halted,
    output logic              fault,
    output logic [3:0]        depth
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_RET_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [3:0]        depth_q, depth_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic              active;
    logic              do_ret;
    logic              do_call;
    logic              ret_ok;
    logic              call_ok;

    assign pc_inc = pc_q + 1'b1;

    // Stack strobes are live only while running unstalled and out of reset.
    assign active  = rst_n && (state_q == S_RUN) && !stall;
    assign do_ret  = active && !is_halt && is_ret;
    assign do_call = active && !is_halt && !is_ret && is_call;

`ifdef RAS_DEPTH_CHECK_EN
    assign ret_ok  = (depth_q != 4'd0);
    assign call_ok = (depth_q != DEPTH_MAX);
`else
    assign ret_ok  = 1'b1;
    assign call_ok = 1'b1;
`endif

    assign pop_sig   = do_ret && ret_ok;
    assign push_sig  = do_call && call_ok;
    assign push_data = pc_inc;
    assign pc        = pc_q;
    assign depth     = depth_q;
    assign halted    = halted_q;
    assign fault     = fault_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        depth_d  = depth_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        case (state_q)
            S_RUN: begin
                if (!stall) begin
                    if (is_halt) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else if (is_ret) begin
                        if (ret_ok) begin
                            state_d = S_RET_WAIT;
                            if (depth_q != 4'd0) depth_d = depth_q - 4'd1;
                        end else begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                            fault_d  = 1'b1;
                        end
                    end else if (is_call) begin
                        if (call_ok) begin
                            pc_d = target;
                            if (depth_q != DEPTH_MAX) depth_d = depth_q + 4'd1;
                        end else begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                            fault_d  = 1'b1;
                        end
                    end else if (is_jump || (is_branch && branch_taken)) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            // Return data arrives one cycle after the pop; this state never stalls.
            S_RET_WAIT: begin
                pc_d    = pop_data;
                state_d = S_RUN;
            end
            S_HALT: begin
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
        // A stack overflow report overrides whatever this cycle decoded.
        if (overflow) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            fault_d  = 1'b1;
            pc_d     = pc_q;
            depth_d  = depth_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            depth_q  <= 4'd0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            depth_q  <= depth_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer with a behavioural 8-entry return stack.
// Covers both builds of RAS_DEPTH_CHECK_EN.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, is_jump, is_branch, branch_taken, is_call, is_ret, is_halt;
    logic [11:0] target;
    logic [11:0] pop_data;
    logic        overflow;
    logic [11:0] pc;
    logic        push_sig, pop_sig;
    logic [11:0] push_data;
    logic        halted, fault;
    logic [3:0]  depth;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [11:0] pc;
        logic [3:0]  depth;
        logic        halted;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .is_jump(is_jump),
        .is_branch(is_branch), .branch_taken(branch_taken), .is_call(is_call),
        .is_ret(is_ret), .is_halt(is_halt), .target(target), .pop_data(pop_data),
        .overflow(overflow), .pc(pc), .push_sig(push_sig), .pop_sig(pop_sig),
        .push_data(push_data), .halted(halted), .fault(fault), .depth(depth)
    );

    // Return-address stack: data valid the cycle after a pop, overflow raised the cycle after a full push.
    logic [11:0] stk [0:7];
    int          sp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp       <= 0;
            pop_data <= 12'h0AA;
            overflow <= 1'b0;
        end else if (push_sig) begin
            if (sp == 8) overflow <= 1'b1;
            else begin
                stk[sp] <= push_data;
                sp      <= sp + 1;
            end
        end else if (pop_sig && sp != 0) begin
            pop_data <= stk[sp-1];
            sp       <= sp - 1;
        end
    end

    // Registered-state comparator: one expectation per clock edge it was queued for.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || depth !== e.depth || halted !== e.halted || fault !== e.fault) begin
                errors++;
                $display("FAIL %s: pc=%h depth=%0d halted=%b fault=%b, expected pc=%h depth=%0d halted=%b fault=%b",
                         e.name, pc, depth, halted, fault, e.pc, e.depth, e.halted, e.fault);
            end else begin
                $display("txn %s: pc=%h depth=%0d halted=%b fault=%b", e.name, pc, depth, halted, fault);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic h, input logic r, input logic c, input logic j,
                          input logic b, input logic t, input logic s, input logic [11:0] tgt);
        is_halt = h; is_ret = r; is_call = c; is_jump = j;
        is_branch = b; branch_taken = t; stall = s; target = tgt;
    endtask

    task automatic push_exp(input string n, input logic [11:0] p, input logic [3:0] d,
                            input logic h, input logic f);
        exp_t e;
        e.name = n; e.pc = p; e.depth = d; e.halted = h; e.fault = f;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(0, 0, 1, 0, 0, 0, 0, 12'h123);
        #2;
        checks++;
        if (pc !== 12'h000 || depth !== 4'd0 || halted !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h depth=%0d halted=%b fault=%b, expected 000/0/0/0", pc, depth, halted, fault);
        end
        checks++;
        if (push_sig !== 1'b0 || pop_sig !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: push=%b pop=%b, expected 0/0", push_sig, pop_sig);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 12'h000);
        push_exp("seq1", 12'h001, 4'd0, 0, 0);
        @(negedge clk); push_exp("seq2", 12'h002, 4'd0, 0, 0);
        @(negedge clk); push_exp("seq3", 12'h003, 4'd0, 0, 0);
        @(negedge clk);
        set_in(0, 0, 1, 0, 0, 0, 0, 12'h005);
        push_exp("call_to_5", 12'h005, 4'd1, 0, 0);
        @(negedge clk);
        set_in(0, 0, 1, 0, 0, 0, 0, 12'h300);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 12'h000 || depth !== 4'd0 || push_sig !== 1'b0 || pop_sig !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pc=%h depth=%0d push=%b pop=%b, expected 000/0/0/0", pc, depth, push_sig, pop_sig);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 12'h000);
        rst_n = 1'b1;
    endtask

    task automatic test_call_ret();
        do_reset();
        set_in(0, 0, 0, 1, 0, 0, 0, 12'h010);
        push_exp("jump_010", 12'h010, 4'd0, 0, 0);
        @(negedge clk);
        set_in(0, 0, 1, 0, 0, 0, 0, 12'h100);
        #1;
        checks++;
        if (push_sig !== 1'b1 || pop_sig !== 1'b0 || push_data !== 12'h011) begin
            errors++;
            $display("FAIL call_strobe: push=%b pop=%b push_data=%h, expected 1/0/011", push_sig, pop_sig, push_data);
        end
        push_exp("call_100", 12'h100, 4'd1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            set_in(0, 0, 0, 0, 0, 0, 0, 12'h000);
            push_exp("seq_after_call", 12'h100 + 12'(i), 4'd1, 0, 0);
        end
        @(negedge clk);
        set_in(0, 1, 0, 0, 0, 0, 0, 12'h000);
        #1;
        checks++;
        if (pop_sig !== 1'b1 || push_sig !== 1'b0) begin
            errors++;
            $display("FAIL ret_strobe: pop=%b push=%b, expected 1/0", pop_sig, push_sig);
        end
        push_exp("ret_wait_pc", 12'h103, 4'd0, 0, 0);
        @(negedge clk);
        set_in(0, 0, 1, 0, 0, 0, 1, 12'h777);
        #1;
        checks++;
        if (push_sig !== 1'b0 || pop_sig !== 1'b0) begin
            errors++;
            $display("FAIL ret_wait_strobes: push=%b pop=%b, expected 0/0", push_sig, pop_sig);
        end
        push_exp("ret_target", 12'h011, 4'd0, 0, 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 12'h000);
        push_exp("after_ret", 12'h012, 4'd0, 0, 0);
        @(negedge clk);
    endtask

    task automatic test_nested_calls();
        logic [11:0] p;
        logic [11:0] t;
        do_reset();
        p = 12'h000;
        for (int i = 0; i < 8; i++) begin
            t = 12'h200 + 12'(i * 16);
            set_in(0, 0, 1, 0, 0, 0, 0, t);
            #1;
            checks++;
            if (push_sig !== 1'b1 || push_data !== p + 12'h001) begin
                errors++;
                $display("FAIL nest_push%0d: push=%b push_data=%h, expected 1/%h", i, push_sig, push_data, p + 12'h001);
            end
            push_exp("nest_call", t, 4'(i + 1), 0, 0);
            p = t;
            @(negedge clk);
        end
        set_in(0, 0, 1, 0, 0, 0, 0, 12'h280);
        #1;
`ifdef RAS_DEPTH_CHECK_EN
        checks++;
        if (push_sig !== 1'b0) begin
            errors++;
            $display("FAIL ninth_call_push: push=%b, expected 0", push_sig);
        end
        push_exp("ninth_call_fault", p, 4'd8, 1, 1);
        @(negedge clk);
`else
        checks++;
        if (push_sig !== 1'b1) begin
            errors++;
            $display("FAIL ninth_call_push: push=%b, expected 1", push_sig);
        end
        push_exp("ninth_call_sat", 12'h280, 4'd8, 0, 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 12'h000);
        push_exp("overflow_fault", 12'h280, 4'd8, 1, 1);
        @(negedge clk);
`endif
    endtask

    task automatic test_empty_ret();
        do_reset();
        set_in(0, 1, 0, 0, 0, 0, 0, 12'h000);
        #1;
`ifdef RAS_DEPTH_CHECK_EN
        checks++;
        if (pop_sig !== 1'b0) begin
            errors++;
            $display("FAIL empty_ret_pop: pop=%b, expected 0", pop_sig);
        end
        push_exp("empty_ret_fault", 12'h000, 4'd0, 1, 1);
        @(negedge clk);
`else
        checks++;
        if (pop_sig !== 1'b1) begin
            errors++;
            $display("FAIL empty_ret_pop: pop=%b, expected 1", pop_sig);
        end
        push_exp("empty_ret_wait", 12'h000, 4'd0, 0, 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 12'h000);
        push_exp("empty_ret_load", 12'h0AA, 4'd0, 0, 0);
        @(negedge clk);
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_in(0, 0, 0, 1, 0, 0, 0, 12'h050);
        push_exp("jump_050", 12'h050, 4'd0, 0, 0);
        @(negedge clk);
        set_in(0, 0, 1, 0, 0, 0, 0, 12'h060);
        push_exp("call_060", 12'h060, 4'd1, 0, 0);
        @(negedge clk);
        set_in(0, 1, 1, 0, 0, 0, 1, 12'h070);
        #1;
        checks++;
        if (push_sig !== 1'b0 || pop_sig !== 1'b0) begin
            errors++;
            $display("FAIL stall_strobes: push=%b pop=%b, expected 0/0", push_sig, pop_sig);
        end
        push_exp("stall_hold", 12'h060, 4'd1, 0, 0);
        @(negedge clk);
        set_in(0, 1, 1, 0, 0, 0, 0, 12'h070);
        #1;
        checks++;
        if (pop_sig !== 1'b1 || push_sig !== 1'b0) begin
            errors++;
            $display("FAIL ret_over_call: pop=%b push=%b, expected 1/0", pop_sig, push_sig);
        end
        push_exp("ret_over_call", 12'h060, 4'd0, 0, 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 1, 12'h000);
        push_exp("ret_wait_ignores_stall", 12'h051, 4'd0, 0, 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 1, 1, 0, 12'h020);
        push_exp("branch_taken", 12'h020, 4'd0, 0, 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 1, 0, 12'h300);
        push_exp("taken_without_branch", 12'h021, 4'd0, 0, 0);
        @(negedge clk);
        set_in(0, 0, 0, 1, 0, 0, 0, 12'hFFF);
        push_exp("jump_fff", 12'hFFF, 4'd0, 0, 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 1, 0, 0, 12'h123);
        #1;
        checks++;
        if (push_data !== 12'h000) begin
            errors++;
            $display("FAIL push_data_wrap: push_data=%h, expected 000", push_data);
        end
        push_exp("branch_not_taken_wrap", 12'h000, 4'd0, 0, 0);
        @(negedge clk);
    endtask

    task automatic test_halt();
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 12'h000);
        push_exp("pre_halt", 12'h001, 4'd0, 0, 0);
        @(negedge clk);
        set_in(1, 0, 1, 0, 0, 0, 0, 12'h400);
        #1;
        checks++;
        if (push_sig !== 1'b0 || pop_sig !== 1'b0) begin
            errors++;
            $display("FAIL halt_priority: push=%b pop=%b, expected 0/0", push_sig, pop_sig);
        end
        push_exp("halt", 12'h001, 4'd0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'b0, 12'($urandom));
            #1;
            checks++;
            if (push_sig !== 1'b0 || pop_sig !== 1'b0) begin
                errors++;
                $display("FAIL halted_strobes%0d: push=%b pop=%b, expected 0/0", i, push_sig, pop_sig);
            end
            push_exp("halted_hold", 12'h001, 4'd0, 1, 0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || pc !== 12'h000) begin
            errors++;
            $display("FAIL halt_reset: halted=%b pc=%h, expected 0/000", halted, pc);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 12'h000);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_nested_calls();
        test_empty_ret();
        test_back_to_back();
        test_halt();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
